// File: rtl/mult_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the shared 16x16 multiplier.
// The slave view belongs to the arbiter; the master view belongs to whoever drives requests and models the multiplier.
interface mult_arbiter_if;
    logic [1:0]  req;
    logic [15:0] a_0;
    logic [15:0] b_0;
    logic [15:0] a_1;
    logic [15:0] b_1;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [31:0] result;
    logic        m_din_rdy;
    logic [7:0]  m_din_1;
    logic [7:0]  m_din_2;
    logic [7:0]  m_din_3;
    logic [7:0]  m_din_4;
    logic        m_dout_rdy;
    logic [7:0]  m_dout_1;
    logic [7:0]  m_dout_2;
    logic [7:0]  m_dout_3;
    logic [7:0]  m_dout_4;

    modport slave (
        input  req, a_0, b_0, a_1, b_1,
        input  m_dout_rdy, m_dout_1, m_dout_2, m_dout_3, m_dout_4,
        output gnt, done, err, result,
        output m_din_rdy, m_din_1, m_din_2, m_din_3, m_din_4
    );

    modport master (
        output req, a_0, b_0, a_1, b_1,
        output m_dout_rdy, m_dout_1, m_dout_2, m_dout_3, m_dout_4,
        input  gnt, done, err, result,
        input  m_din_rdy, m_din_1, m_din_2, m_din_3, m_din_4
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one external multiplier between two requesters,
// with a per-transaction WAIT timeout. All outputs are registered.
module mult_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    mult_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);

    state_t      state_r;
    logic [1:0]  gnt_r;
    logic [1:0]  done_r;
    logic [1:0]  err_r;
    logic [31:0] result_r;
    logic        din_rdy_r;
    logic [31:0] opnd_r;
    logic [15:0] cnt_r;
    logic        prio_r;

    logic        any_s;
    logic        sel_s;
    logic [16:0] cnt_next_s;
    logic        tmo_hit_s;

    // Pick the requester to serve next; prio_r breaks ties and names the one not served last.
    always_comb begin
        any_s      = 1'b0;
        sel_s      = 1'b0;
        cnt_next_s = {1'b0, cnt_r} + 17'd1;
        tmo_hit_s  = (cnt_next_s == TIMEOUT_W);
        case (bus.req)
            2'b01:   begin any_s = 1'b1; sel_s = 1'b0;   end
            2'b10:   begin any_s = 1'b1; sel_s = 1'b1;   end
            2'b11:   begin any_s = 1'b1; sel_s = prio_r; end
            default: begin any_s = 1'b0; sel_s = 1'b0;   end
        endcase
    end

    // Transaction state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            gnt_r     <= 2'b00;
            done_r    <= 2'b00;
            err_r     <= 2'b00;
            result_r  <= 32'd0;
            din_rdy_r <= 1'b0;
            opnd_r    <= 32'd0;
            cnt_r     <= 16'd0;
            prio_r    <= 1'b0;
        end else begin
            done_r <= 2'b00;
            err_r  <= 2'b00;
            case (state_r)
                ST_IDLE: begin
                    if (any_s) begin
                        gnt_r     <= sel_s ? 2'b10 : 2'b01;
                        opnd_r    <= sel_s ? {bus.a_1, bus.b_1} : {bus.a_0, bus.b_0};
                        din_rdy_r <= 1'b1;
                        state_r   <= ST_ISSUE;
                    end else begin
                        gnt_r     <= 2'b00;
                        din_rdy_r <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    din_rdy_r <= 1'b0;
                    cnt_r     <= 16'd0;
                    state_r   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion is checked first so a result arriving on the last allowed cycle still wins.
                    if (bus.m_dout_rdy) begin
                        result_r <= {bus.m_dout_1, bus.m_dout_2, bus.m_dout_3, bus.m_dout_4};
                        done_r   <= gnt_r;
                        prio_r   <= ~gnt_r[1];
                        opnd_r   <= 32'd0;
                        state_r  <= ST_DONE;
                    end else if (tmo_hit_s) begin
                        err_r    <= gnt_r;
                        gnt_r    <= 2'b00;
                        prio_r   <= ~gnt_r[1];
                        opnd_r   <= 32'd0;
                        state_r  <= ST_IDLE;
                    end else begin
                        cnt_r    <= cnt_next_s[15:0];
                        state_r  <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    gnt_r   <= 2'b00;
                    state_r <= ST_IDLE;
                end
                default: begin
                    gnt_r     <= 2'b00;
                    din_rdy_r <= 1'b0;
                    opnd_r    <= 32'd0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.result    = result_r;
    assign bus.m_din_rdy = din_rdy_r;
    assign bus.m_din_1   = opnd_r[31:24];
    assign bus.m_din_2   = opnd_r[23:16];
    assign bus.m_din_3   = opnd_r[15:8];
    assign bus.m_din_4   = opnd_r[7:0];

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: one instance at the default timeout, one at TIMEOUT=8.
module tb_mult_arbiter;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    mult_arbiter_if mb ();
    mult_arbiter_if tb_if ();

    mult_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (mb)
    );

    mult_arbiter #(.TIMEOUT(8)) dut_to (
        .clk (clk),
        .rst (rst),
        .bus (tb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] din_main();
        return {mb.m_din_1, mb.m_din_2, mb.m_din_3, mb.m_din_4};
    endfunction

    function automatic logic [31:0] din_to();
        return {tb_if.m_din_1, tb_if.m_din_2, tb_if.m_din_3, tb_if.m_din_4};
    endfunction

    // One full transaction on the main instance; starts and ends on an IDLE-cycle negedge.
    task automatic run_main(input string tag, input logic [1:0] req_v, input logic [1:0] req_hold,
                            input logic [15:0] a0, input logic [15:0] b0,
                            input logic [15:0] a1, input logic [15:0] b1,
                            input logic [1:0] exp_gnt, input logic [31:0] exp_din,
                            input logic [31:0] prod, input int n_wait);
        mb.req = req_v;
        mb.a_0 = a0; mb.b_0 = b0; mb.a_1 = a1; mb.b_1 = b1;
        @(negedge clk);
        chk({tag, ".issue_gnt"}, {30'd0, mb.gnt}, {30'd0, exp_gnt});
        chk({tag, ".issue_rdy"}, {31'd0, mb.m_din_rdy}, 32'd1);
        chk({tag, ".issue_din"}, din_main(), exp_din);
        mb.req = req_hold;
        mb.a_0 = ~a0; mb.b_0 = ~b0; mb.a_1 = ~a1; mb.b_1 = ~b1;
        @(negedge clk);
        chk({tag, ".wait_rdy"}, {31'd0, mb.m_din_rdy}, 32'd0);
        chk({tag, ".wait_din"}, din_main(), exp_din);
        repeat (n_wait - 1) @(negedge clk);
        chk({tag, ".wait_gnt"}, {30'd0, mb.gnt}, {30'd0, exp_gnt});
        chk({tag, ".wait_done"}, {30'd0, mb.done}, 32'd0);
        {mb.m_dout_1, mb.m_dout_2, mb.m_dout_3, mb.m_dout_4} = prod;
        mb.m_dout_rdy = 1'b1;
        @(negedge clk);
        chk({tag, ".done"}, {30'd0, mb.done}, {30'd0, exp_gnt});
        chk({tag, ".done_err"}, {30'd0, mb.err}, 32'd0);
        chk({tag, ".result"}, mb.result, prod);
        chk({tag, ".done_din"}, din_main(), 32'd0);
        mb.m_dout_rdy = 1'b0;
        {mb.m_dout_1, mb.m_dout_2, mb.m_dout_3, mb.m_dout_4} = 32'd0;
        @(negedge clk);
        chk({tag, ".idle_done"}, {30'd0, mb.done}, 32'd0);
        chk({tag, ".idle_gnt"}, {30'd0, mb.gnt}, 32'd0);
        chk({tag, ".idle_result"}, mb.result, prod);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        mb.req = 2'b00; mb.a_0 = 16'd0; mb.b_0 = 16'd0; mb.a_1 = 16'd0; mb.b_1 = 16'd0;
        mb.m_dout_rdy = 1'b0;
        {mb.m_dout_1, mb.m_dout_2, mb.m_dout_3, mb.m_dout_4} = 32'd0;
        tb_if.req = 2'b00; tb_if.a_0 = 16'd0; tb_if.b_0 = 16'd0; tb_if.a_1 = 16'd0; tb_if.b_1 = 16'd0;
        tb_if.m_dout_rdy = 1'b0;
        {tb_if.m_dout_1, tb_if.m_dout_2, tb_if.m_dout_3, tb_if.m_dout_4} = 32'd0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst.gnt", {30'd0, mb.gnt}, 32'd0);
        chk("rst.done", {30'd0, mb.done}, 32'd0);
        chk("rst.err", {30'd0, mb.err}, 32'd0);
        chk("rst.result", mb.result, 32'd0);
        chk("rst.rdy", {31'd0, mb.m_din_rdy}, 32'd0);
        chk("rst.din", din_main(), 32'd0);
        chk("rst.to_gnt", {30'd0, tb_if.gnt}, 32'd0);

        // Single request, 10 WAIT cycles; req dropped and operands changed after grant.
        run_main("single", 2'b01, 2'b00, 16'h0003, 16'h0005, 16'h0000, 16'h0000,
                 2'b01, 32'h0003_0005, 32'h0000_000F, 10);

        // Reset restores the pointer so contention starts with requester 0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_main("rr1", 2'b11, 2'b11, 16'd2, 16'd3, 16'd4, 16'd5, 2'b01, 32'h0002_0003, 32'd6, 2);
        run_main("rr2", 2'b11, 2'b11, 16'd2, 16'd3, 16'd4, 16'd5, 2'b10, 32'h0004_0005, 32'd20, 3);
        run_main("rr3", 2'b11, 2'b00, 16'd2, 16'd3, 16'd4, 16'd5, 2'b01, 32'h0002_0003, 32'd6, 1);

        run_main("maxw", 2'b01, 2'b00, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000,
                 2'b01, 32'hFFFF_FFFF, 32'hFFFE_0001, 4);

        // Reset in WAIT, then a late result must be ignored.
        mb.req = 2'b01; mb.a_0 = 16'd7; mb.b_0 = 16'd9;
        @(negedge clk);
        chk("rstw.gnt", {30'd0, mb.gnt}, 32'd1);
        mb.req = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mb.m_dout_rdy = 1'b1;
        {mb.m_dout_1, mb.m_dout_2, mb.m_dout_3, mb.m_dout_4} = 32'd63;
        @(negedge clk);
        chk("rstw.done", {30'd0, mb.done}, 32'd0);
        chk("rstw.err", {30'd0, mb.err}, 32'd0);
        chk("rstw.gnt0", {30'd0, mb.gnt}, 32'd0);
        chk("rstw.result", mb.result, 32'd0);
        chk("rstw.rdy", {31'd0, mb.m_din_rdy}, 32'd0);
        chk("rstw.din", din_main(), 32'd0);
        mb.m_dout_rdy = 1'b0;
        @(negedge clk);
        chk("rstw.done2", {30'd0, mb.done}, 32'd0);

        // TIMEOUT=8 instance: establish a result first.
        tb_if.req = 2'b01; tb_if.a_0 = 16'd6; tb_if.b_0 = 16'd7;
        @(negedge clk);
        chk("to.pre_din", din_to(), 32'h0006_0007);
        tb_if.req = 2'b00;
        repeat (3) @(negedge clk);
        {tb_if.m_dout_1, tb_if.m_dout_2, tb_if.m_dout_3, tb_if.m_dout_4} = 32'h0000_002A;
        tb_if.m_dout_rdy = 1'b1;
        @(negedge clk);
        chk("to.pre_result", tb_if.result, 32'h0000_002A);
        tb_if.m_dout_rdy = 1'b0;
        @(negedge clk);

        // No result ever: err follows the 8th WAIT cycle.
        tb_if.req = 2'b01; tb_if.a_0 = 16'd1; tb_if.b_0 = 16'd1;
        @(negedge clk);
        chk("to.issue_gnt", {30'd0, tb_if.gnt}, 32'd1);
        tb_if.req = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk($sformatf("to.wait%0d_err", i), {30'd0, tb_if.err}, 32'd0);
            chk($sformatf("to.wait%0d_gnt", i), {30'd0, tb_if.gnt}, 32'd1);
        end
        @(negedge clk);
        chk("to.err", {30'd0, tb_if.err}, 32'd1);
        chk("to.err_done", {30'd0, tb_if.done}, 32'd0);
        chk("to.err_gnt", {30'd0, tb_if.gnt}, 32'd0);
        chk("to.err_result", tb_if.result, 32'h0000_002A);
        chk("to.err_din", din_to(), 32'd0);
        @(negedge clk);
        chk("to.err_pulse", {30'd0, tb_if.err}, 32'd0);

        // Result on exactly the 8th WAIT cycle: completion wins.
        tb_if.req = 2'b01; tb_if.a_0 = 16'h0100; tb_if.b_0 = 16'h0100;
        @(negedge clk);
        tb_if.req = 2'b00;
        repeat (8) @(negedge clk);
        {tb_if.m_dout_1, tb_if.m_dout_2, tb_if.m_dout_3, tb_if.m_dout_4} = 32'h0001_0000;
        tb_if.m_dout_rdy = 1'b1;
        @(negedge clk);
        chk("bnd.done", {30'd0, tb_if.done}, 32'd1);
        chk("bnd.err", {30'd0, tb_if.err}, 32'd0);
        chk("bnd.result", tb_if.result, 32'h0001_0000);
        tb_if.m_dout_rdy = 1'b0;
        @(negedge clk);
        chk("bnd.err2", {30'd0, tb_if.err}, 32'd0);
        chk("bnd.gnt", {30'd0, tb_if.gnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum WAIT-state cycles before a request is aborted; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req  input  2  request lines; bit i = requester i wants a product.
REQ-005 a_0, b_0  input  16 each  requester 0 operands.
REQ-006 a_1, b_1  input  16 each  requester 1 operands.
REQ-007 gnt  output  2  one-hot grant; held high from grant through completion.
REQ-008 done  output  2  one-cycle pulse on bit i when requester i's transaction completes.
REQ-009 err  output  2  one-cycle pulse on bit i when requester i's transaction times out.
REQ-010 result  output  32  product of the most recent completed transaction; held until the next completion.
REQ-011 m_din_rdy  output  1  start strobe to the shared multiplier.
REQ-012 m_din_1, m_din_2, m_din_3, m_din_4  output  8 each  operand bytes: A[15:8], A[7:0], B[15:8], B[7:0].
REQ-013 m_dout_rdy  input  1  multiplier result-valid.
REQ-014 m_dout_1, m_dout_2, m_dout_3, m_dout_4  input  8 each  product bytes [31:24], [23:16], [15:8], [7:0].

Function
REQ-015 The state machine SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-016 In IDLE with req != 0, the block SHALL grant one requester, latch its a/b into internal 16-bit registers, set gnt and go to ISSUE on the next edge.
REQ-017 Arbitration SHALL be round-robin: when both req bits are set, the requester not granted last wins; the pointer after reset favours requester 0.
REQ-018 The round-robin pointer SHALL update only on done or err.
REQ-019 In ISSUE, m_din_rdy SHALL be high for exactly one cycle with the latched operand bytes on m_din_1..4; the next state is WAIT.
REQ-020 m_din_1..4 SHALL hold the latched operands from ISSUE until leaving WAIT; they are 0 in IDLE.
REQ-021 In WAIT, the first cycle with m_dout_rdy=1 SHALL capture {m_dout_1..4} into result and move to DONE.
REQ-022 m_dout_rdy SHALL be ignored in IDLE, ISSUE and DONE.
REQ-023 A 16-bit WAIT-cycle counter SHALL clear on entering WAIT and increment each WAIT cycle.
REQ-024 If the counter reaches TIMEOUT without m_dout_rdy, err[granted] SHALL pulse for one cycle, result SHALL be unchanged, gnt SHALL clear and the state SHALL return to IDLE.
REQ-025 If m_dout_rdy arrives in the same cycle the counter reaches TIMEOUT, completion SHALL win and no err is raised.
REQ-026 In DONE, done[granted] SHALL be high for one cycle, gnt SHALL clear and the next state is IDLE.
REQ-027 Transaction latency SHALL be: grant edge, 1 ISSUE cycle, N WAIT cycles, then done in the cycle after capture.
REQ-028 A new grant is possible in the cycle after DONE; there SHALL be no back-to-back overlap.
REQ-029 Dropping req during a transaction SHALL NOT abort it; done still pulses.
REQ-030 Operand changes after the grant SHALL NOT affect the transaction in progress.
REQ-031 gnt, done and err SHALL each be one-hot or zero at all times; done and err are never high together.

Reset
REQ-032 While rst=1 at a rising edge, the block SHALL go to IDLE and clear gnt, done, err, result, m_din_rdy, m_din_1..4, the counter and the latched operands.
REQ-033 While rst=1 at a rising edge, the round-robin pointer SHALL be set to favour requester 0.
REQ-034 A reset mid-transaction SHALL abandon the transaction with no done or err pulse.
REQ-035 After a mid-transaction reset, a late m_dout_rdy SHALL be ignored because the block is in IDLE.

Verification
REQ-036 Single request: req=01, a_0=0x0003, b_0=0x0005, model returns 0x0000000F after 10 cycles -> one m_din_rdy pulse with bytes 00,03,00,05; done=01 pulse; result=0x0000000F.
REQ-037 Contention: req=11 held, a_0=2, b_0=3, a_1=4, b_1=5 -> first grant 01, result 6; then grant 10, result 20; then grant 01 again.
REQ-038 Maximum width: a_0=0xFFFF, b_0=0xFFFF -> result=0xFFFE0001.
REQ-039 Timeout: TIMEOUT=8 with m_dout_rdy never asserted -> err=01 pulse in WAIT cycle 8; result keeps its previous value; gnt=00; IDLE.
REQ-040 Reset in WAIT: rst=1 for one cycle, then m_dout_rdy=1 -> no done or err; all outputs 0.
REQ-041 Boundary: m_dout_rdy in the same cycle the counter reaches TIMEOUT -> done, no err.
